lfsr_rng_arbiter: RTL and testbench
===================================

// Module: lfsr_rng_arbiter
// PURPOSE
//  Owns one 8-bit maximal-length LFSR and shares its output between NUM_REQ requesters.
//  Sequences the LFSR through seed load and a warm-up run, then serves one value per grant.
//  Requesters are served round-robin, and no two grants ever receive the same LFSR state.
//  Sits between the random-number consumers (game/test logic) and the LFSR datapath.
// PARAMETERS
//  NUM_REQ  4      number of requesters, 2..8
//  SEED     8'h01  reset and fallback seed; must be nonzero
//  WARMUP   8      LFSR steps run after reset/reseed before serving, 1..255
// PORTS
//  clk      in   1        single clock, all state updates on posedge
//  reset    in   1        synchronous, active-high; overrides every other input
//  req      in   NUM_REQ  per-requester request, level; held until gnt seen
//  reseed   in   1        one-cycle pulse: load seed_in and rerun warm-up
//  seed_in  in   8        seed value, sampled when reseed is accepted
//  gnt      out  NUM_REQ  one-hot grant, registered, high for exactly 1 cycle
//  valid    out  1        high when gnt is nonzero (data is valid)
//  data     out  8        random value for the granted requester
//  ready    out  1        high in SERVE state only
// BEHAVIOUR
//  Reset
//   - lfsr=SEED, state=WARMUP, warm counter=0.
//   - gnt=0, valid=0, data=8'h00, ready=0.
//   - Round-robin pointer is set so requester 0 has top priority.
//  LFSR step (left-shift Galois, poly x^8+x^6+x^5+x^4+1, period 255)
//   - next = {q[6:0],1'b0} ^ (q[7] ? 8'h71 : 8'h00).
//   - Example sequence from 01: 01,02,04,08,10,20,40,80,71,E2,B5.
//  States
//   - WARMUP: LFSR steps every cycle; after WARMUP steps go to SERVE. req and reseed are ignored.
//   - SERVE: ready=1. Each edge, reseed has priority over req:
//     - reseed=1: go to RESEED; no grant is issued on that edge.
//     - Otherwise, if any eligible req: register gnt for the winner, valid=1, data=current lfsr, and step the LFSR on the same edge.
//     - If no eligible req: LFSR holds (no free-running).
//   - RESEED: one cycle. lfsr=(seed_in==0) ? SEED : seed_in, with seed_in sampled on the accepting edge. Counter=0, then go to WARMUP.
//  Arbitration
//   - Round-robin: search starts at (last winner + 1) mod NUM_REQ.
//   - A requester whose gnt is high on an edge is ineligible on that edge. This prevents a double grant when req drops the cycle after gnt.
//  Latency and throughput
//   - req sampled at edge k -> gnt/valid/data high during cycle k+1.
//   - Throughput is 1 grant/cycle aggregate, 1 grant per 2 cycles per requester.
//  Outputs while not granting
//   - gnt=0, valid=0; data holds its last granted value.
//  Reset mid-operation: any state returns to the reset values on the next edge; an in-flight grant is dropped.
//  reseed in the same cycle as an outstanding gnt: that grant completes; no new grant is issued until SERVE is re-entered.
//  Never load all-zero into the LFSR. The block guarantees the fallback to SEED.
// STRUCTURE
//  Shared package (lfsr_pkg): LFSR_W=8, LFSR_TAPS=8'h71, state encoding (WARMUP, SERVE, RESEED).
//  Sub-module lfsr8_galois (clk, reset, load, load_val, step, q)
//   - Inputs: clk, reset, load, load_val, step. Output: q.
//   - load has priority over step; reset loads SEED.
//  Top level holds the FSM, warm-up counter, RR pointer and output registers.
// TESTING (SEED=01, WARMUP=8, NUM_REQ=4)
//  1. Reset, then idle: ready rises after 8 post-reset edges; lfsr=71; gnt=0 throughout warm-up.
//  2. req=0001 held 1 cycle after gnt: single gnt=0001 with data=71; next grant to req0 gives E2.
//  3. req=1111 held: gnts 0001,0010,0100,1000,0001 with data 71,E2,B5,... (no repeats, no double grant).
//  4. reseed with seed_in=00 in SERVE: RESEED, then 8 warm-up cycles, then first data=71.
//     reseed with seed_in=80: first data after warm-up = 80 stepped 8 times.
//  5. reset asserted mid-grant with req=1111: next cycle gnt=0, valid=0, ready=0, lfsr=01.
//  6. reseed and req0 in the same SERVE edge: no gnt issued; req0 is served after warm-up with its pointer priority.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit Galois LFSR and its round-robin arbiter:
// width, tap mask, FSM encoding, debug view and the single-step function.
package lfsr_pkg;

   localparam int                LFSR_W    = 8;
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'h71;

   typedef enum logic [1:0] {
      ST_WARMUP = 2'd0,
      ST_SERVE  = 2'd1,
      ST_RESEED = 2'd2
   } arb_state_t;

   typedef struct packed {
      arb_state_t        state;
      logic [LFSR_W-1:0] lfsr;
      logic [7:0]        warm_cnt;
   } arb_dbg_t;

   // Left-shift Galois step for x^8+x^6+x^5+x^4+1
   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
      return {q[LFSR_W-2:0], 1'b0} ^ (q[LFSR_W-1] ? LFSR_TAPS : '0);
   endfunction

endpackage

// File: rtl/lfsr8_galois.sv
// 8-bit Galois LFSR register. Reset loads SEED; load wins over step;
// with neither asserted the value holds.
module lfsr8_galois
   import lfsr_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = 8'h01
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [LFSR_W-1:0] load_val,
   input  logic              step,
   output logic [LFSR_W-1:0] q
);

   always_ff @(posedge clk) begin
      if (reset) begin
         q <= SEED;
      end else if (load) begin
         q <= load_val;
      end else if (step) begin
         q <= lfsr_next(q);
      end
   end

endmodule

// File: rtl/lfsr_rng_arbiter.sv
// Shares one LFSR among NUM_REQ requesters: warm-up after reset/reseed, then
// one registered grant per cycle, round-robin, each grant taking a fresh state.
//
// Handshake: a requester holds req high until it sees its gnt bit; gnt, valid
// and data are registered and last exactly one cycle. A requester whose gnt is
// high is not eligible on that edge, so dropping req one cycle late is safe.
module lfsr_rng_arbiter
   import lfsr_pkg::*;
#(
   parameter int                NUM_REQ = 4,
   parameter logic [LFSR_W-1:0] SEED    = 8'h01,
   parameter int                WARMUP  = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   input  logic               reseed,
   input  logic [LFSR_W-1:0]  seed_in,
   output logic [NUM_REQ-1:0] gnt,
   output logic               valid,
   output logic [LFSR_W-1:0]  data,
   output logic               ready,
   output arb_dbg_t           dbg
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   arb_state_t        state, state_nx;
   logic [7:0]        warm_cnt, warm_cnt_nx;
   logic [PW-1:0]     rr_ptr;
   logic [LFSR_W-1:0] lfsr_q, load_val;
   logic              lfsr_load, lfsr_step, grant_en;
   logic [NUM_REQ-1:0] eligible;
   logic              win_found;
   logic [PW-1:0]     win_idx;
   int                idx_i;

   lfsr8_galois #(.SEED(SEED)) u_lfsr (
      .clk      (clk),
      .reset    (reset),
      .load     (lfsr_load),
      .load_val (load_val),
      .step     (lfsr_step),
      .q        (lfsr_q)
   );

   assign eligible = req & ~gnt;

   // First eligible requester at or after rr_ptr, wrapping
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      idx_i     = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx_i = (int'(rr_ptr) + i) % NUM_REQ;
         if (!win_found && eligible[PW'(idx_i)]) begin
            win_found = 1'b1;
            win_idx   = PW'(idx_i);
         end
      end
   end

   always_comb begin
      state_nx    = state;
      warm_cnt_nx = warm_cnt;
      lfsr_load   = 1'b0;
      lfsr_step   = 1'b0;
      load_val    = SEED;
      grant_en    = 1'b0;
      case (state)
         ST_WARMUP: begin
            lfsr_step   = 1'b1;
            warm_cnt_nx = warm_cnt + 8'd1;
            if (warm_cnt == 8'(WARMUP - 1)) state_nx = ST_SERVE;
         end
         ST_SERVE: begin
            if (reseed) begin
               // An all-zero seed would lock the LFSR, so fall back to SEED
               lfsr_load = 1'b1;
               load_val  = (seed_in == '0) ? SEED : seed_in;
               state_nx  = ST_RESEED;
            end else if (win_found) begin
               grant_en  = 1'b1;
               lfsr_step = 1'b1;
            end
         end
         ST_RESEED: begin
            warm_cnt_nx = '0;
            state_nx    = ST_WARMUP;
         end
         default: state_nx = ST_WARMUP;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_WARMUP;
         warm_cnt <= '0;
         rr_ptr   <= '0;
         gnt      <= '0;
         valid    <= 1'b0;
         data     <= '0;
      end else begin
         state    <= state_nx;
         warm_cnt <= warm_cnt_nx;
         if (grant_en) begin
            gnt    <= NUM_REQ'(1) << win_idx;
            valid  <= 1'b1;
            data   <= lfsr_q;
            rr_ptr <= (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + PW'(1);
         end else begin
            gnt   <= '0;
            valid <= 1'b0;
         end
      end
   end

   assign ready = (state == ST_SERVE);

   assign dbg.state    = state;
   assign dbg.lfsr     = lfsr_q;
   assign dbg.warm_cnt = warm_cnt;

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// Bench for lfsr_rng_arbiter: behavioural model checked every cycle, plus a
// scoreboard of hand-computed {gnt,data} pairs for the directed scenarios.
module tb_lfsr_rng_arbiter;
   import lfsr_pkg::*;

   localparam int N     = 4;
   localparam int WARM  = 8;
   localparam int W     = 12;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [N-1:0] req = '0;
   logic         reseed = 1'b0;
   logic [7:0]   seed_in = 8'h00;
   logic [N-1:0] gnt;
   logic         valid;
   logic [7:0]   data;
   logic         ready;
   arb_dbg_t     dbg;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];
   bit sb_on = 1'b0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   lfsr_rng_arbiter #(.NUM_REQ(N), .SEED(8'h01), .WARMUP(WARM)) dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .reseed  (reseed),
      .seed_in (seed_in),
      .gnt     (gnt),
      .valid   (valid),
      .data    (data),
      .ready   (ready),
      .dbg     (dbg)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] step8(input logic [7:0] v);
      return ((v * 2) % 256) ^ ((v >= 8'h80) ? 8'h71 : 8'h00);
   endfunction

   // ---------------- behavioural model ----------------
   int           m_mode = 0;       // 0 warming, 1 serving, 2 one-cycle reseed
   int           m_warm_left = WARM;
   int           m_last = N - 1;
   logic [7:0]   m_lfsr = 8'h01;
   logic [7:0]   m_data = 8'h00;
   logic [N-1:0] m_gnt = '0;
   bit           m_valid = 1'b0;

   always @(posedge clk) begin
      logic [N-1:0] elig;
      int           w;
      elig = req & ~m_gnt;
      w = -1;
      if (reset) begin
         m_mode = 0; m_warm_left = WARM; m_last = N - 1; m_lfsr = 8'h01;
         m_data = 8'h00; m_gnt = '0; m_valid = 1'b0;
      end else begin
         m_gnt = '0;
         m_valid = 1'b0;
         if (m_mode == 0) begin
            m_lfsr = step8(m_lfsr);
            m_warm_left--;
            if (m_warm_left == 0) m_mode = 1;
         end else if (m_mode == 2) begin
            m_mode = 0;
            m_warm_left = WARM;
         end else if (reseed) begin
            m_lfsr = (seed_in == 8'h00) ? 8'h01 : seed_in;
            m_mode = 2;
         end else begin
            for (int k = 1; k <= N; k++)
               if (w < 0 && elig[(m_last + k) % N]) w = (m_last + k) % N;
            if (w >= 0) begin
               m_gnt = N'(1) << w;
               m_valid = 1'b1;
               m_data = m_lfsr;
               m_lfsr = step8(m_lfsr);
               m_last = w;
            end
         end
      end
   end

   // ---------------- compare / scoreboard ----------------
   always @(negedge clk) begin
      logic [W-1:0] e;
      check("gnt", 32'(gnt), 32'(m_gnt));
      check("valid", 32'(valid), 32'(m_valid));
      check("data", 32'(data), 32'(m_data));
      check("ready", 32'(ready), 32'(m_mode == 1));
      check("lfsr", 32'(dbg.lfsr), 32'(m_lfsr));
      if (sb_on && valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected actual=%0h expected=none", {gnt, data});
         end else begin
            e = exp_q.pop_front();
            check("sb_grant", 32'({gnt, data}), 32'(e));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
   endtask

   task automatic wait_ready(input int bound, output int edges);
      edges = 0;
      while (ready !== 1'b1 && edges < bound) begin
         tick(1);
         edges++;
      end
      if (ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL wait_ready actual=timeout required=ready within %0d", bound);
      end
   endtask

   task automatic pulse_reseed(input logic [7:0] s);
      seed_in = s;
      reseed = 1'b1;
      tick(1);
      reseed = 1'b0;
      seed_in = 8'hAA;   // only the accepting edge may sample seed_in
   endtask

   initial begin
      int edges;
      // 1. reset values and warm-up length
      tick(2);
      reset = 1'b0;
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_valid", 32'(valid), 32'h0);
      check("rst_data", 32'(data), 32'h0);
      check("rst_ready", 32'(ready), 32'h0);
      check("rst_lfsr", 32'(dbg.lfsr), 32'h01);
      wait_ready(20, edges);
      check("warm_edges", 32'(edges), 32'd8);
      check("warm_lfsr", 32'(dbg.lfsr), 32'h71);

      // 2. single requester, req held through its gnt cycle
      sb_on = 1'b1;
      exp_q.push_back(12'h171);
      exp_q.push_back(12'h1E2);
      req = 4'b0001;
      tick(1);
      check("t2_gnt", 32'(gnt), 32'h1);
      check("t2_data", 32'(data), 32'h71);
      tick(1);
      check("t2_no_double", 32'(gnt), 32'h0);
      check("t2_data_hold", 32'(data), 32'h71);
      req = '0;
      tick(1);
      req = 4'b0001;
      tick(1);
      check("t2_second", 32'(data), 32'hE2);
      req = '0;
      tick(2);

      // 3. all requesters held, fresh pointer
      do_reset();
      wait_ready(20, edges);
      exp_q.push_back(12'h171);
      exp_q.push_back(12'h2E2);
      exp_q.push_back(12'h4B5);
      exp_q.push_back(12'h81B);
      exp_q.push_back(12'h136);
      req = 4'b1111;
      tick(5);
      req = '0;
      tick(2);
      check("t3_drain", 32'(exp_q.size()), 32'd0);

      // 4. reseed with zero falls back to SEED; reseed beside an outstanding gnt
      pulse_reseed(8'h00);
      check("t4_ready_low", 32'(ready), 32'h0);
      check("t4_lfsr_fallback", 32'(dbg.lfsr), 32'h01);
      wait_ready(30, edges);
      check("t4_reseed_edges", 32'(edges), 32'd9);
      exp_q.push_back(12'h171);
      req = 4'b0001;
      tick(1);
      req = '0;
      pulse_reseed(8'h80);
      check("t4_gnt_done", 32'(gnt), 32'h0);
      check("t4_lfsr_80", 32'(dbg.lfsr), 32'h80);
      wait_ready(30, edges);
      exp_q.push_back(12'h2C1);
      req = 4'b0010;
      tick(1);
      req = '0;
      tick(2);
      check("t4_drain", 32'(exp_q.size()), 32'd0);

      // 5. reset in the middle of a grant burst
      sb_on = 1'b0;
      req = 4'b1111;
      tick(2);
      reset = 1'b1;
      tick(1);
      check("t5_gnt", 32'(gnt), 32'h0);
      check("t5_valid", 32'(valid), 32'h0);
      check("t5_ready", 32'(ready), 32'h0);
      check("t5_lfsr", 32'(dbg.lfsr), 32'h01);
      reset = 1'b0;
      req = '0;
      wait_ready(20, edges);

      // 6. reseed and request on the same edge: reseed wins, pointer untouched
      sb_on = 1'b1;
      exp_q.push_back(12'h171);
      exp_q.push_back(12'h2E2);
      req = 4'b0011;
      pulse_reseed(8'h00);
      check("t6_no_gnt", 32'(gnt), 32'h0);
      wait_ready(30, edges);
      tick(2);
      req = '0;
      tick(2);
      check("t6_drain", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule
